// File: rtl/sched_pkg.sv
// Shared types and constants for the round-robin process scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SAVE   = 3'd2,
    S_SELECT = 3'd3,
    S_LOAD   = 3'd4
  } sched_state_t;

  localparam int NUM_PROC_DEF = 4;
  localparam int PROC_ID_W    = $clog2(NUM_PROC_DEF);

  // Output values while Reset is asserted
  localparam logic RST_CHANGE_PC  = 1'b0;
  localparam logic RST_EXEC_PROC  = 1'b0;
  localparam logic RST_SCHED_HALT = 1'b1;
  localparam logic RST_SCHED_BUSY = 1'b0;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Rotate-priority finder: returns the first valid slot after cur, wrapping,
// with cur itself examined last.
module sched_rr_arbiter
  import sched_pkg::*;
#(
  parameter int N = NUM_PROC_DEF,
  parameter int W = PROC_ID_W
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next,
  output logic         found
);

  // Scan offsets 1..N; offset N truncates to cur itself
  always_comb begin
    logic [W-1:0] idx;
    next  = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= N; i++) begin
      idx = cur + W'(i);
      if (!found && valid[idx]) begin
        next  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin preemptive scheduler beside the PC. Preempts on quantum expiry or
// process termination, saves the frozen PC per slot, reloads via change_pc/pc_in.
// Optional build macro SCHED_SWITCH_CNT_EN adds the saturating switch_count output.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 5,
  parameter int QUANTUM  = 8,
  localparam int PID_W   = $clog2(NUM_PROC)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                sched_en,
  input  logic [ADDR_W-1:0]   pc_current,
  input  logic [CNT_W-1:0]    pc_counter,
  input  logic                pc_redirect,
  input  logic                proc_done,
  input  logic                proc_create,
  input  logic [PID_W-1:0]    proc_create_id,
  input  logic [ADDR_W-1:0]   proc_create_addr,
  output logic                change_pc,
  output logic [ADDR_W-1:0]   pc_in,
  output logic                exec_proc,
  output logic                sched_halt,
  output logic [PID_W-1:0]    cur_proc,
  output logic [NUM_PROC-1:0] proc_valid,
  output logic                sched_busy
`ifdef SCHED_SWITCH_CNT_EN
  ,output logic [15:0]        switch_count
`endif
);

  localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(QUANTUM);

  sched_state_t        state_r, state_s;
  logic                done_r, done_s;           // current SAVE was caused by proc_done
  logic                from_idle_r, from_idle_s; // SELECT entered from IDLE: scan starts at cur
  logic [PID_W-1:0]    cur_s;
  logic [PID_W-1:0]    arb_cur_s, arb_next_s;
  logic                arb_found_s;
  logic                clr_valid_s, save_we_s;
  logic [NUM_PROC-1:0] set_mask_s, clr_mask_s;
  logic [ADDR_W-1:0]   pc_in_s;
  logic [ADDR_W-1:0]   table_r [NUM_PROC];

  // Nothing was preempted when leaving IDLE, so the scan includes cur itself first
  assign arb_cur_s = from_idle_r ? (cur_proc - PID_W'(1)) : cur_proc;

  sched_rr_arbiter #(.N(NUM_PROC), .W(PID_W)) u_arb (
    .valid (proc_valid),
    .cur   (arb_cur_s),
    .next  (arb_next_s),
    .found (arb_found_s)
  );

  // Next-state logic and per-state side effects
  always_comb begin
    state_s     = state_r;
    done_s      = done_r;
    from_idle_s = from_idle_r;
    cur_s       = cur_proc;
    clr_valid_s = 1'b0;
    save_we_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sched_en && (|proc_valid)) begin
          state_s     = S_SELECT;
          from_idle_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (proc_done) begin
          state_s = S_SAVE;
          done_s  = 1'b1;
        end else if (sched_en && (pc_counter >= QUANTUM_C)) begin
          state_s = S_SAVE;
          done_s  = 1'b0;
        end else begin
          state_s = S_RUN;
        end
      end
      S_SAVE: begin
        if (pc_redirect) begin
          state_s = S_SAVE;
        end else begin
          state_s     = S_SELECT;
          from_idle_s = 1'b0;
          if (done_r) begin
            clr_valid_s = 1'b1;
          end else begin
            save_we_s = 1'b1;
          end
        end
      end
      S_SELECT: begin
        if (arb_found_s) begin
          cur_s   = arb_next_s;
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (pc_redirect) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_RUN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Valid-bitmap update masks; a create overrides a clear on the same slot
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (proc_create) begin
      set_mask_s[proc_create_id] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (clr_valid_s) begin
      clr_mask_s[cur_proc] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
  end

  // Reload address, forwarding a same-cycle create on the target slot
  always_comb begin
    if (proc_create && (proc_create_id == cur_s)) begin
      pc_in_s = proc_create_addr;
    end else begin
      pc_in_s = table_r[cur_s];
    end
  end

  // FSM state, slot bookkeeping and registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      done_r      <= 1'b0;
      from_idle_r <= 1'b0;
      cur_proc    <= '0;
      proc_valid  <= '0;
      change_pc   <= RST_CHANGE_PC;
      pc_in       <= '0;
      exec_proc   <= RST_EXEC_PROC;
      sched_halt  <= RST_SCHED_HALT;
      sched_busy  <= RST_SCHED_BUSY;
    end else begin
      state_r     <= state_s;
      done_r      <= done_s;
      from_idle_r <= from_idle_s;
      cur_proc    <= cur_s;
      proc_valid  <= (proc_valid & ~clr_mask_s) | set_mask_s;
      change_pc   <= (state_s == S_LOAD);
      exec_proc   <= (state_s == S_RUN);
      sched_halt  <= (state_s != S_RUN);
      sched_busy  <= (state_s == S_SAVE) || (state_s == S_SELECT) || (state_s == S_LOAD);
      if (state_s == S_LOAD) begin
        pc_in <= pc_in_s;
      end
    end
  end

  // Per-slot PC table; a create beats a save on the same slot
  always_ff @(posedge Clock) begin
    for (int i = 0; i < NUM_PROC; i++) begin
      if (proc_create && (proc_create_id == PID_W'(i))) begin
        table_r[i] <= proc_create_addr;
      end else if (save_we_s && (cur_proc == PID_W'(i))) begin
        table_r[i] <= pc_current;
      end
    end
  end

`ifdef SCHED_SWITCH_CNT_EN
  // Saturating count of completed LOAD->RUN transitions
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      switch_count <= 16'd0;
    end else if ((state_r == S_LOAD) && (state_s == S_RUN) && (switch_count != 16'hFFFF)) begin
      switch_count <= switch_count + 16'd1;
    end
  end
`endif

endmodule
